// File: rtl/sd_cmd_serial_host.sv
// SD command-line serialiser.
// Shifts out a 40-bit command token followed by its CRC7 and an end bit.
// When a response is expected, it then collects the card's 48-bit response
// and checks the CRC7 and the end bit.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line released, serial_ready high, waiting for req_in
// SEND      | driving the 48-bit command frame, one bit per clock
// WAIT_RESP | line released, watching for the response start bit
// RECEIVE   | shifting in the remaining 47 response bits
// DONE      | ack_out high with the results stable, waiting for req_in low
module sd_cmd_serial_host #(
    parameter int TIMEOUT = 64,
    parameter int NCR_MIN = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_in,
    input  logic [39:0] cmd_in,
    input  logic        resp_expected,
    output logic        ack_out,
    output logic [39:0] cmd_out,
    output logic        serial_ready,
    output logic        crc_err,
    output logic        timeout_err,
    input  logic        cmd_pin_in,
    output logic        cmd_pin_out,
    output logic        cmd_pin_oe
);
    localparam int CW = $clog2(TIMEOUT + 1);
    // The wait timer counts down from TIMEOUT-1.
    // The elapsed count is therefore (TIMEOUT-1 - wait_cnt).
    localparam logic [CW-1:0] WAIT_LOAD  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] DETECT_MAX = CW'(TIMEOUT - 1 - NCR_MIN);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECEIVE, DONE} state_t;

    state_t        state, state_next;
    logic [39:0]   tx_shift;
    logic [46:0]   rx_bits;
    logic [6:0]    crc;
    logic [5:0]    bit_cnt;
    logic [CW-1:0] wait_cnt;
    logic          resp_latched;
    logic          start_seen;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign start_seen = (state == WAIT_RESP) && (wait_cnt <= DETECT_MAX) && !cmd_pin_in;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and pin/handshake outputs.
    always_comb begin
        state_next  = state;
        ack_out     = 1'b0;
        cmd_pin_oe  = 1'b0;
        cmd_pin_out = 1'b1;
        case (state)
            IDLE: begin
                if (req_in) state_next = SEND;
            end
            SEND: begin
                cmd_pin_oe = 1'b1;
                if (bit_cnt < 6'd40) begin
                    cmd_pin_out = tx_shift[39];
                end else if (bit_cnt < 6'd47) begin
                    cmd_pin_out = crc[6];
                end else begin
                    cmd_pin_out = 1'b1;
                    state_next  = resp_latched ? WAIT_RESP : DONE;
                end
            end
            WAIT_RESP: begin
                if (start_seen)           state_next = RECEIVE;
                else if (wait_cnt == '0)  state_next = DONE;
            end
            RECEIVE: begin
                if (bit_cnt == 6'd47) state_next = DONE;
            end
            DONE: begin
                ack_out = 1'b1;
                if (!req_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: token latch, CRC, bit/wait counters, response capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            serial_ready <= 1'b0;
            cmd_out      <= '0;
            crc_err      <= 1'b0;
            timeout_err  <= 1'b0;
            crc          <= '0;
            tx_shift     <= '0;
            rx_bits      <= '0;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            resp_latched <= 1'b0;
        end else begin
            serial_ready <= (state_next == IDLE);
            case (state)
                IDLE: begin
                    if (req_in) begin
                        tx_shift     <= cmd_in;
                        resp_latched <= resp_expected;
                        crc_err      <= 1'b0;
                        timeout_err  <= 1'b0;
                        crc          <= '0;
                        bit_cnt      <= '0;
                    end
                end
                SEND: begin
                    bit_cnt  <= bit_cnt + 6'd1;
                    wait_cnt <= WAIT_LOAD;
                    if (bit_cnt < 6'd40) begin
                        crc      <= crc7_step(crc, tx_shift[39]);
                        tx_shift <= {tx_shift[38:0], 1'b0};
                    end else if (bit_cnt < 6'd47) begin
                        crc <= {crc[5:0], 1'b0};
                    end
                end
                WAIT_RESP: begin
                    if (start_seen) begin
                        // A zero start bit leaves a zero CRC at zero.
                        crc     <= '0;
                        rx_bits <= '0;
                        bit_cnt <= 6'd1;
                    end else if (wait_cnt == '0) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                RECEIVE: begin
                    bit_cnt <= bit_cnt + 6'd1;
                    rx_bits <= {rx_bits[45:0], cmd_pin_in};
                    if (bit_cnt <= 6'd39) crc <= crc7_step(crc, cmd_pin_in);
                    // The last bit is still on cmd_pin_in.
                    // The full frame is therefore {rx_bits, cmd_pin_in}.
                    if (bit_cnt == 6'd47) begin
                        cmd_out <= rx_bits[46:7];
                        crc_err <= (crc != rx_bits[6:0]) || !cmd_pin_in;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_serial_host.sv
// Bench for sd_cmd_serial_host.
// A driver issues directed commands and plays the card.
// Two monitors check the transmitted frames and the ack results against queues.
module tb_sd_cmd_serial_host;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_in;
    logic [39:0] cmd_in;
    logic        resp_expected;
    logic        ack_out;
    logic [39:0] cmd_out;
    logic        serial_ready;
    logic        crc_err;
    logic        timeout_err;
    logic        cmd_pin_in;
    logic        cmd_pin_out;
    logic        cmd_pin_oe;

    typedef struct packed {
        logic [39:0] cmd;
        logic        crc;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    logic [47:0] frame_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        abort_frame = 1'b0;
    logic        ack_prev = 1'b0;
    logic [47:0] line_sh = '0;
    int          line_cnt = 0;

    sd_cmd_serial_host #(.TIMEOUT(64), .NCR_MIN(2)) dut (
        .clock(clock), .reset(reset), .req_in(req_in), .cmd_in(cmd_in),
        .resp_expected(resp_expected), .ack_out(ack_out), .cmd_out(cmd_out),
        .serial_ready(serial_ready), .crc_err(crc_err), .timeout_err(timeout_err),
        .cmd_pin_in(cmd_pin_in), .cmd_pin_out(cmd_pin_out), .cmd_pin_oe(cmd_pin_oe)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Line monitor: collect driven bits, compare a frame when the line is released.
    always @(negedge clock) begin
        if (cmd_pin_oe) begin
            line_sh = {line_sh[46:0], cmd_pin_out};
            line_cnt++;
        end else if (line_cnt != 0) begin
            if (!abort_frame) begin
                if (frame_q.size() == 0) begin
                    chk("frame_unexpected", line_sh, 48'h0);
                end else begin
                    chk("frame_len", line_cnt, 48);
                    chk("frame_bits", line_sh, frame_q.pop_front());
                end
            end
            line_cnt = 0;
        end
    end

    // Ack monitor: compare results when ack_out rises.
    always @(negedge clock) begin
        exp_t e;
        if (ack_out && !ack_prev) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", ack_out, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("cmd_out", cmd_out, e.cmd);
                chk("crc_err", crc_err, e.crc);
                chk("timeout_err", timeout_err, e.to);
            end
        end
        ack_prev = ack_out;
    end

    task automatic run_txn(input string tag, input logic [39:0] c, input logic re,
                           input logic [47:0] ef, input logic [39:0] eo, input logic ecrc,
                           input logic eto, input logic card_on, input logic [47:0] rf,
                           input int dly, input logic glitch, input int lat);
        int   n;
        int   rel;
        exp_t e;
        e.cmd = eo; e.crc = ecrc; e.to = eto;
        frame_q.push_back(ef);
        exp_q.push_back(e);
        @(negedge clock);
        chk({tag, "_ready"}, serial_ready, 1'b1);
        req_in = 1'b1; cmd_in = c; resp_expected = re;
        n = 0;
        while (!cmd_pin_oe && n < 8) begin @(negedge clock); n++; end
        // The command must already be latched.
        cmd_in = ~c; resp_expected = ~re;
        n = 0;
        while (cmd_pin_oe && n < 60) begin @(negedge clock); n++; end
        rel = cyc;
        if (card_on) begin
            for (int t = 0; t < dly + 48; t++) begin
                if (glitch && t == 1)  cmd_pin_in = 1'b0;
                else if (t >= dly)     cmd_pin_in = rf[47 - (t - dly)];
                else                   cmd_pin_in = 1'b1;
                @(negedge clock);
            end
            cmd_pin_in = 1'b1;
        end
        n = 0;
        while (!ack_out && n < 100) begin @(negedge clock); n++; end
        chk({tag, "_ack_latency"}, cyc - rel, lat);
        @(negedge clock);
        chk({tag, "_ack_held"}, ack_out, 1'b1);
        req_in = 1'b0;
        @(negedge clock);
        chk({tag, "_ack_drop"}, ack_out, 1'b0);
        chk({tag, "_ready_back"}, serial_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; req_in = 1'b0; cmd_in = '0; resp_expected = 1'b0; cmd_pin_in = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_ack", ack_out, 1'b0);
        chk("rst_ready", serial_ready, 1'b0);
        chk("rst_oe", cmd_pin_oe, 1'b0);
        chk("rst_pin", cmd_pin_out, 1'b1);
        chk("rst_cmd_out", cmd_out, 40'h0);
        chk("rst_crc_err", crc_err, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready_rise", serial_ready, 1'b1);

        // Reset during SEND cycle 20.
        abort_frame = 1'b1;
        req_in = 1'b1; cmd_in = 40'h4000000000; resp_expected = 1'b0;
        n = 0;
        while (!cmd_pin_oe && n < 8) begin @(negedge clock); n++; end
        repeat (20) @(negedge clock);
        chk("mid_send_oe", cmd_pin_oe, 1'b1);
        reset = 1'b1; req_in = 1'b0;
        @(negedge clock);
        chk("midrst_oe", cmd_pin_oe, 1'b0);
        chk("midrst_pin", cmd_pin_out, 1'b1);
        chk("midrst_ack", ack_out, 1'b0);
        chk("midrst_ready", serial_ready, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_ready_rise", serial_ready, 1'b1);
        abort_frame = 1'b0;

        run_txn("cmd0", 40'h4000000000, 1'b0, 48'h400000000095, 40'h0, 1'b0, 1'b0,
                1'b0, 48'h0, 0, 1'b0, 0);
        run_txn("ncr_glitch", 40'h48000001AA, 1'b1, 48'h48000001AA87, 40'h08000001AA, 1'b0, 1'b0,
                1'b1, 48'h08000001AA13, 3, 1'b1, 51);
        run_txn("cmd8", 40'h48000001AA, 1'b1, 48'h48000001AA87, 40'h08000001AA, 1'b0, 1'b0,
                1'b1, 48'h08000001AA13, 5, 1'b0, 53);
        run_txn("bad_crc", 40'h48000001AA, 1'b1, 48'h48000001AA87, 40'h08000001AA, 1'b1, 1'b0,
                1'b1, 48'h08000001AA15, 5, 1'b0, 53);
        run_txn("bad_end", 40'h48000001AA, 1'b1, 48'h48000001AA87, 40'h08000001AA, 1'b1, 1'b0,
                1'b1, 48'h08000001AA12, 5, 1'b0, 53);
        run_txn("cmd17_to", 40'h5100000000, 1'b1, 48'h510000000055, 40'h08000001AA, 1'b0, 1'b1,
                1'b0, 48'h0, 0, 1'b0, 64);

        repeat (2) @(negedge clock);
        chk("frames_left", frame_q.size(), 0);
        chk("acks_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sd_cmd_serial_host.md
Name: sd_cmd_serial_host

Overview:
- Serial command physical layer that sits directly downstream of the SD command controller.
- Accepts a 40-bit command token (start bit, transmission bit, index, argument) over a req/ack handshake, appends CRC7 and an end bit, and shifts the 48-bit frame out MSB-first on the CMD line.
- Then releases the line, waits for the card's 48-bit response, captures it, checks its CRC7 and end bit, and returns the 40-bit response token to the controller.
- Runs one bit per clock; the clock is the SD card clock.

Parameters:
- TIMEOUT, 64, max clock cycles to wait for a response start bit after the line is released.
- NCR_MIN, 2, cycles after release before start-bit detection is enabled.

Ports:
- clock  input  1  SD bit clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_in  input  1  level request from controller; cmd_in valid while high.
- cmd_in  input  40  command token, bit 39 sent first (bit 39 = 0 start, bit 38 = 1 transmission).
- resp_expected  input  1  1 = wait for a response after sending; sampled with req_in.
- ack_out  output  1  transaction complete; held until req_in falls.
- cmd_out  output  40  captured response frame bits [47:8].
- serial_ready  output  1  block idle and able to accept req_in.
- crc_err  output  1  response CRC7 or end-bit mismatch; valid with ack_out.
- timeout_err  output  1  no response start bit within TIMEOUT; valid with ack_out.
- cmd_pin_in  input  1  sampled CMD line (pulled up; idle = 1).
- cmd_pin_out  output  1  driven CMD line value.
- cmd_pin_oe  output  1  1 = block drives CMD line.

Behaviour:
- Reset (synchronous, active-high, wins over everything, including mid-frame): state = IDLE; ack_out = 0; serial_ready = 0; cmd_out = 0; crc_err = 0; timeout_err = 0; cmd_pin_out = 1; cmd_pin_oe = 0; CRC register cleared. serial_ready rises 1 cycle after reset deasserts.
- IDLE: serial_ready = 1, cmd_pin_oe = 0. When req_in = 1, latch cmd_in and resp_expected, clear crc_err, timeout_err and the CRC register, set serial_ready = 0, and go to SEND.
- SEND: cmd_pin_oe = 1 for exactly 48 cycles. Cycles 0-39 drive cmd_in[39..0]. Cycles 40-46 drive CRC7[6..0]. Cycle 47 drives 1 (end bit).
- CRC7 polynomial is x^7 + x^3 + 1, initial value 0, computed over the 40 token bits only.
- After the end bit, cmd_pin_oe = 0 and cmd_pin_out = 1.
  - If resp_expected = 0, go to DONE.
  - If resp_expected = 1, go to WAIT_RESP.
- WAIT_RESP: a cycle counter starts at 0. cmd_pin_in is ignored while count < NCR_MIN.
  - A 0 on cmd_pin_in with count >= NCR_MIN is the start bit: capture it as bit 47 and go to RECEIVE.
  - If count reaches TIMEOUT with no start bit: set timeout_err = 1 and go to DONE.
- RECEIVE: capture the next 47 bits MSB-first; the 48-bit frame is complete 47 cycles after the start bit.
  - CRC7 is computed over frame bits [47:8] and compared with [7:1].
  - crc_err = 1 if the CRC mismatches or bit 0 != 1.
  - cmd_out = frame[47:8]. Go to DONE.
- DONE: ack_out = 1, with cmd_out, crc_err and timeout_err stable. When req_in = 0, clear ack_out the next cycle and return to IDLE; serial_ready returns to 1 in that same cycle.
- req_in changes while not in IDLE or DONE are ignored; the latched command is used.
- If req_in is still 1 on return to IDLE, it starts a new transaction; the controller must drop req_in to avoid this.
- cmd_out holds its last value until the next response capture. It is not cleared on timeout.
- The block never drives cmd_pin_oe outside SEND.

Test Plan:
- Reset mid-SEND (cycle 20) -> next cycle: cmd_pin_oe = 0, cmd_pin_out = 1, ack_out = 0, serial_ready = 0; serial_ready = 1 one cycle after reset release.
- CMD0: cmd_in = 40'h4000000000, resp_expected = 0 -> line shows 48'h400000000095 over 48 cycles; ack_out = 1 the cycle after the end bit; crc_err = 0, timeout_err = 0; ack_out drops 1 cycle after req_in falls.
- CMD8: cmd_in = 40'h48000001AA, resp_expected = 1 -> line shows 48'h48000001AA87. Card model drives 48'h08000001AA13 starting 5 cycles after release -> cmd_out = 40'h08000001AA, crc_err = 0.
- Same as the CMD8 case but the response CRC byte is 8'h15 -> crc_err = 1. Separately, end bit = 0 -> crc_err = 1.
- CMD17: cmd_in = 40'h5100000000 (frame 48'h510000000055), resp_expected = 1, card silent -> timeout_err = 1 and ack_out = 1 at count 64; cmd_out keeps its previous value.
- Card model drives a 0 at release + 1 cycle, before NCR_MIN -> ignored; a valid response started at release + 3 cycles is captured correctly.
